// File: rtl/io_map_pkg.sv
// Shared IO-space constants for the LEGv8 GPIO/timer controller:
// base address byte, register offsets and bit positions.
package io_map_pkg;
    localparam logic [7:0] IO_BASE      = 8'h05;

    localparam logic [7:0] REG_CTRL     = 8'd0;
    localparam logic [7:0] REG_PRESCALE = 8'd1;
    localparam logic [7:0] REG_COMPARE  = 8'd2;
    localparam logic [7:0] REG_GPIO_OUT = 8'd3;
    localparam logic [7:0] REG_COUNT    = 8'd4;
    localparam logic [7:0] REG_STATUS   = 8'd5;
    localparam logic [7:0] REG_GPIO_IN  = 8'd6;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_BITS    = 3;
    localparam int STATUS_MATCH = 0;
endpackage

// File: rtl/io_timer_controller_if.sv
// CPU data-memory side of the IO controller: address/strobes in,
// load data and IO-space select out.
interface io_timer_controller_if;
    logic [63:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        io_select;

    modport master (output address, mem_read, mem_write, write_data,
                    input  read_data, io_select);
    modport slave  (input  address, mem_read, mem_write, write_data,
                    output read_data, io_select);
endinterface

// File: rtl/io_timer_core.sv
// Timer datapath: prescaler, 64-bit COUNT, COMPARE and the sticky match flag.
// Register writes arrive as pre-decoded strobes sharing one data bus.
module io_timer_core
    import io_map_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      auto_reload,
    input  logic                      wr_prescale,
    input  logic                      wr_compare,
    input  logic                      wr_count,
    input  logic                      wr_status,
    input  logic [63:0]               wdata,
    output logic [PRESCALE_WIDTH-1:0] prescale_o,
    output logic [63:0]               compare_o,
    output logic [63:0]               count_o,
    output logic                      match_flag_o
);
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
    logic [63:0]               compare_q, compare_d;
    logic [63:0]               count_q, count_d;
    logic                      match_q, match_d;
    logic                      tick;
    logic                      hit;

    always_comb begin
        tick       = enable && (psc_q == prescale_q);
        hit        = (count_q == compare_q);
        prescale_d = prescale_q;
        psc_d      = psc_q;
        compare_d  = compare_q;
        count_d    = count_q;
        match_d    = match_q;

        if (enable)
            psc_d = tick ? '0 : psc_q + 1'b1;
        if (tick)
            count_d = (hit && auto_reload) ? 64'd0 : count_q + 64'd1;

        // A match set in the same cycle as a software clear must stick.
        if (wr_status && wdata[STATUS_MATCH])
            match_d = 1'b0;
        if (tick && hit)
            match_d = 1'b1;

        if (wr_prescale) begin
            prescale_d = wdata[PRESCALE_WIDTH-1:0];
            psc_d      = '0;
        end
        if (wr_compare)
            compare_d = wdata;
        // CPU load of COUNT overrides the increment/reload of this tick.
        if (wr_count)
            count_d = wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_q <= '0;
            psc_q      <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
        end
    end

    assign prescale_o   = prescale_q;
    assign compare_o    = compare_q;
    assign count_o      = count_q;
    assign match_flag_o = match_q;
endmodule

// File: rtl/io_timer_controller.sv
// Memory-mapped GPIO/timer controller: address decode, CTRL and GPIO
// registers, input synchronizer and zero-latency load mux.
module io_timer_controller
    import io_map_pkg::*;
#(
    parameter int GPIO_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    io_timer_controller_if.slave  bus,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);
    logic [7:0]                offset;
    logic                      io_sel;
    logic                      wr_en;
    logic [CTRL_BITS-1:0]      ctrl_q, ctrl_d;
    logic [GPIO_WIDTH-1:0]     gpio_q, gpio_d;
    logic [GPIO_WIDTH-1:0]     sync1_q, sync2_q;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [63:0]               compare;
    logic [63:0]               count;
    logic                      match_flag;
    logic [63:0]               rd_mux;

    assign offset        = bus.address[7:0];
    assign io_sel        = (bus.address[63:56] == IO_BASE) && (bus.mem_read || bus.mem_write);
    assign wr_en         = io_sel && bus.mem_write;
    assign bus.io_select = io_sel;

    always_comb begin
        ctrl_d = ctrl_q;
        gpio_d = gpio_q;
        if (wr_en && offset == REG_CTRL)
            ctrl_d = bus.write_data[CTRL_BITS-1:0];
        if (wr_en && offset == REG_GPIO_OUT)
            gpio_d = bus.write_data[GPIO_WIDTH-1:0];
    end

    // sync1/sync2 form the two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q  <= '0;
            gpio_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            gpio_q  <= gpio_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    io_timer_core #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_core (
        .clock        (clock),
        .reset        (reset),
        .enable       (ctrl_q[CTRL_EN]),
        .auto_reload  (ctrl_q[CTRL_AR]),
        .wr_prescale  (wr_en && offset == REG_PRESCALE),
        .wr_compare   (wr_en && offset == REG_COMPARE),
        .wr_count     (wr_en && offset == REG_COUNT),
        .wr_status    (wr_en && offset == REG_STATUS),
        .wdata        (bus.write_data),
        .prescale_o   (prescale),
        .compare_o    (compare),
        .count_o      (count),
        .match_flag_o (match_flag)
    );

    always_comb begin
        rd_mux = '0;
        case (offset)
            REG_CTRL:     rd_mux[CTRL_BITS-1:0]      = ctrl_q;
            REG_PRESCALE: rd_mux[PRESCALE_WIDTH-1:0] = prescale;
            REG_COMPARE:  rd_mux                     = compare;
            REG_GPIO_OUT: rd_mux[GPIO_WIDTH-1:0]     = gpio_q;
            REG_COUNT:    rd_mux                     = count;
            REG_STATUS:   rd_mux[STATUS_MATCH]       = match_flag;
            REG_GPIO_IN:  rd_mux[GPIO_WIDTH-1:0]     = sync2_q;
            default:      rd_mux                     = '0;
        endcase
    end

    assign bus.read_data = (io_sel && bus.mem_read) ? rd_mux : 64'd0;
    assign gpio_out      = gpio_q;
    assign timer_irq     = match_flag && ctrl_q[CTRL_IE];
endmodule

// File: tb/tb_io_timer_controller.sv
// Bench for io_timer_controller: constant vector table, hand-written timer
// corner sequences, then random traffic against a behavioural register model.
module tb_io_timer_controller;
    logic       clock;
    logic       rst;
    logic [7:0] gin;
    logic [7:0] gout;
    logic       irq;

    io_timer_controller_if bus();

    io_timer_controller #(.GPIO_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clock     (clock),
        .reset     (rst),
        .bus       (bus),
        .gpio_in   (gin),
        .gpio_out  (gout),
        .timer_irq (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the programmer-visible state.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [63:0] m_cmp;
    logic [63:0] m_cnt;
    logic        m_flag;
    logic [7:0]  m_gpio;
    logic [7:0]  m_pipe [2];
    int          m_since;

    function automatic logic m_sel();
        return (bus.address[63:56] == 8'h05) && (bus.mem_read || bus.mem_write);
    endfunction

    function automatic logic [63:0] model_read();
        if (!(m_sel() && bus.mem_read)) return 64'd0;
        case (bus.address[7:0])
            8'd0: return {61'd0, m_ctrl};
            8'd1: return {48'd0, m_pre};
            8'd2: return m_cmp;
            8'd3: return {56'd0, m_gpio};
            8'd4: return m_cnt;
            8'd5: return {63'd0, m_flag};
            8'd6: return {56'd0, m_pipe[1]};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        we, tick, eq;
        logic [7:0]  off;
        logic [63:0] wd, cnt_n;
        logic        flag_n;
        int          since_n;
        off = bus.address[7:0];
        wd  = bus.write_data;
        we  = m_sel() && bus.mem_write;
        if (rst) begin
            m_ctrl = 0; m_pre = 0; m_cmp = 0; m_cnt = 0; m_flag = 0;
            m_gpio = 0; m_pipe[0] = 0; m_pipe[1] = 0; m_since = 0;
            return;
        end
        // A tick happens once every PRESCALE+1 enabled cycles.
        tick    = m_ctrl[0] && (m_since == int'(m_pre));
        eq      = (m_cnt == m_cmp);
        since_n = m_ctrl[0] ? (tick ? 0 : m_since + 1) : m_since;
        cnt_n   = tick ? ((eq && m_ctrl[1]) ? 64'd0 : m_cnt + 64'd1) : m_cnt;
        flag_n  = (tick && eq) ? 1'b1 : ((we && off == 8'd5 && wd[0]) ? 1'b0 : m_flag);
        if (we) begin
            case (off)
                8'd0: m_ctrl = wd[2:0];
                8'd1: begin m_pre = wd[15:0]; since_n = 0; end
                8'd2: m_cmp = wd;
                8'd3: m_gpio = wd[7:0];
                8'd4: cnt_n = wd;
                default: ;
            endcase
        end
        m_cnt = cnt_n; m_flag = flag_n; m_since = since_n;
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = gin;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] wd);
        bus.mem_read = rd; bus.mem_write = wr; bus.address = addr; bus.write_data = wd;
    endtask

    task automatic step();
        $display("[TB] t=%0t rst=%0b rd=%0b wr=%0b addr=%h wd=%h rdata=%h sel=%0b gpio=%h irq=%0b",
                 $time, rst, bus.mem_read, bus.mem_write, bus.address, bus.write_data,
                 bus.read_data, bus.io_select, gout, irq);
        @(posedge clock);
        model_step();
        #1;
    endtask

    function automatic logic [63:0] io_addr(input logic [7:0] off);
        return {8'h05, 48'd0, off};
    endfunction

    task automatic wr(input logic [7:0] off, input logic [63:0] wd);
        drive(1'b0, 1'b1, io_addr(off), wd); #3; step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic rd_chk(input logic [7:0] off, input logic [63:0] exp, input string name);
        drive(1'b1, 1'b0, io_addr(off), 64'd0); #3;
        check(name, bus.read_data, exp);
        step();
        drive(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'd0, 64'd0); #3; step();
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(1'b0, 1'b0, 64'd0, 64'd0); #3; step(); rst = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        exp_sel;
        logic [63:0] exp_rd;
        logic [7:0]  exp_gpio;
    } vec_t;
    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 64'h0500_0000_0000_0004, 64'h0,   1'b1, 64'h0,  8'h00};
        vecs[1]  = '{1'b1, 1'b0, 64'h0000_0000_0000_0004, 64'h0,   1'b0, 64'h0,  8'h00};
        vecs[2]  = '{1'b0, 1'b1, 64'h0500_0000_0000_0003, 64'hA5,  1'b1, 64'h0,  8'h00};
        vecs[3]  = '{1'b1, 1'b0, 64'h0500_0000_0000_0003, 64'h0,   1'b1, 64'hA5, 8'hA5};
        vecs[4]  = '{1'b0, 1'b1, 64'h0500_0000_0000_0003, 64'h1FF, 1'b1, 64'h0,  8'hA5};
        vecs[5]  = '{1'b1, 1'b0, 64'h0500_0000_0000_0003, 64'h0,   1'b1, 64'hFF, 8'hFF};
        vecs[6]  = '{1'b1, 1'b0, 64'h0500_0000_0000_0007, 64'h0,   1'b1, 64'h0,  8'hFF};
        vecs[7]  = '{1'b0, 1'b1, 64'h0500_0000_0000_0007, 64'h55,  1'b1, 64'h0,  8'hFF};
        vecs[8]  = '{1'b1, 1'b0, 64'h0500_0000_0000_0000, 64'h0,   1'b1, 64'h0,  8'hFF};
        vecs[9]  = '{1'b1, 1'b1, 64'h0500_0000_0000_0003, 64'h12,  1'b1, 64'hFF, 8'hFF};
        vecs[10] = '{1'b1, 1'b0, 64'h0500_0000_0000_0003, 64'h0,   1'b1, 64'h12, 8'h12};
        vecs[11] = '{1'b1, 1'b0, 64'h05AB_CDEF_0012_3403, 64'h0,   1'b1, 64'h12, 8'h12};
        vecs[12] = '{1'b0, 1'b0, 64'h0500_0000_0000_0003, 64'h0,   1'b0, 64'h0,  8'h12};
        vecs[13] = '{1'b0, 1'b1, 64'h0600_0000_0000_0003, 64'h77,  1'b0, 64'h0,  8'h12};
        vecs[14] = '{1'b1, 1'b0, 64'h0500_0000_0000_0003, 64'h0,   1'b1, 64'h12, 8'h12};

        gin = 8'h00;
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        step(); step();
        rst = 1'b0;
        #3;
        check("reset_irq", {63'd0, irq}, 64'd0);
        check("reset_gpio", {56'd0, gout}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd); #3;
            check($sformatf("vec%0d_sel", i), {63'd0, bus.io_select}, {63'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rdata", i), bus.read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio", i), {56'd0, gout}, {56'd0, vecs[i].exp_gpio});
            step();
        end

        // Timer with prescale 2 and auto-reload: COUNT steps every 3rd cycle.
        do_reset();
        wr(8'd1, 64'd2);
        wr(8'd2, 64'd3);
        wr(8'd0, 64'd7);
        for (int e = 0; e <= 12; e++) begin
            drive(1'b1, 1'b0, io_addr(8'd4), 64'd0); #3;
            check($sformatf("psc_count_e%0d", e), bus.read_data, (e == 12) ? 64'd0 : 64'(e / 3));
            check($sformatf("psc_irq_e%0d", e), {63'd0, irq}, (e == 12) ? 64'd1 : 64'd0);
            step();
        end
        wr(8'd5, 64'd1);
        #3;
        check("status_clear_irq", {63'd0, irq}, 64'd0);

        // Wrap from all ones to zero without a flag.
        do_reset();
        wr(8'd2, 64'd5);
        wr(8'd0, 64'd1);
        wr(8'd4, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(8'd1, 64'd0);
        rd_chk(8'd4, 64'd0, "wrap_count");
        rd_chk(8'd5, 64'd0, "wrap_flag");
        wr(8'd4, 64'h10);
        rd_chk(8'd4, 64'h10, "count_write_wins");
        rd_chk(8'd4, 64'h11, "count_incr_after_write");
        wr(8'd2, 64'h42);
        wr(8'd4, 64'h40);
        idle(); idle();
        wr(8'd5, 64'd1);
        rd_chk(8'd5, 64'd1, "match_set_beats_clear");
        #1;
        check("irq_masked", {63'd0, irq}, 64'd0);

        // GPIO input synchronizer latency.
        gin = 8'h00; idle(); idle();
        gin = 8'h3C;
        rd_chk(8'd6, 64'h00, "gpio_in_edge0");
        rd_chk(8'd6, 64'h00, "gpio_in_edge1");
        rd_chk(8'd6, 64'h3C, "gpio_in_edge2");

        // Reset mid-count beats a same-cycle COUNT write.
        wr(8'd3, 64'h5A);
        idle(); idle();
        rst = 1'b1; drive(1'b0, 1'b1, io_addr(8'd4), 64'h99); #3; step(); rst = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0); #3;
        check("midreset_gpio", {56'd0, gout}, 64'd0);
        rd_chk(8'd4, 64'd0, "midreset_count");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0]  top, off;
            logic [63:0] wd;
            top = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h05;
            off = 8'($urandom_range(0, 8));
            case (off)
                8'd1:      wd = {$urandom, $urandom} & 64'hFFFF_FFFF_FFF0_0003;
                8'd2, 8'd4: wd = 64'($urandom_range(0, 12));
                default:   wd = {$urandom, $urandom};
            endcase
            rst = ($urandom_range(0, 99) == 0);
            gin = 8'($urandom);
            drive(1'($urandom), ($urandom_range(0, 3) == 0),
                  {top, 24'($urandom), 24'($urandom), off}, wd);
            #3;
            check($sformatf("rnd%0d_rdata", n), bus.read_data, model_read());
            check($sformatf("rnd%0d_sel", n), {63'd0, bus.io_select}, {63'd0, m_sel()});
            check($sformatf("rnd%0d_gpio", n), {56'd0, gout}, {56'd0, m_gpio});
            check($sformatf("rnd%0d_irq", n), {63'd0, irq}, {63'd0, m_flag && m_ctrl[2]});
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
